pixel_port_arbiter: RTL and testbench

- Shares the single VGA adapter pixel-write port between up to `NUM_REQ` drawing engines, for example the box drawer and the screen clearer.
- Each engine requests the port and receives an exclusive grant for a burst of pixel writes; the block forwards the owner's pixels through one output register.
- Sits between the drawing engines and the VGA adapter (`oX`/`oY`/`oColour`/`oPlot`).
- Arbitration is round-robin, so no engine can starve another.

---
 rtl/pixel_port_arbiter_if.sv | 37 +++
 rtl/pixel_port_arbiter.sv | 169 ++++++++++++++++
 tb/tb_pixel_port_arbiter.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/pixel_port_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : pixel_port_arbiter_if
//  Purpose  : Bundles the drawing-engine request/pixel bus and the VGA-side
//             pixel-write outputs of pixel_port_arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
interface pixel_port_arbiter_if #(
  parameter int NUM_REQ = 2
);
  logic [NUM_REQ-1:0]   iReq;
  logic [NUM_REQ-1:0]   iValid;
  logic [NUM_REQ-1:0]   iLast;
  logic [8*NUM_REQ-1:0] iX;
  logic [7*NUM_REQ-1:0] iY;
  logic [3*NUM_REQ-1:0] iColour;
  logic [NUM_REQ-1:0]   oGrant;
  logic                 oBusy;
  logic [7:0]           oX;
  logic [6:0]           oY;
  logic [2:0]           oColour;
  logic                 oPlot;
  logic                 oTimeout;

  // Drawing-engine side (drives requests and pixels)
  modport master (
    output iReq, iValid, iLast, iX, iY, iColour,
    input  oGrant, oBusy, oX, oY, oColour, oPlot, oTimeout
  );

  // Arbiter side
  modport slave (
    input  iReq, iValid, iLast, iX, iY, iColour,
    output oGrant, oBusy, oX, oY, oColour, oPlot, oTimeout
  );
endinterface
`default_nettype wire

// File: rtl/pixel_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : pixel_port_arbiter
//  Purpose  : Round-robin arbiter sharing the single VGA pixel-write port
//             between NUM_REQ drawing engines. The owner keeps the port for a
//             whole burst; its pixels pass through one output register.
//             Optional burst watchdog: define ARB_WATCHDOG_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module pixel_port_arbiter #(
  parameter int NUM_REQ   = 2,
  parameter int MAX_BURST = 19200
) (
  input  logic                 iClock,
  input  logic                 iReset,
  pixel_port_arbiter_if.slave  bus
);

  localparam int c_PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [0:0] c_ST_IDLE = 1'b0;
  localparam logic [0:0] c_ST_OWN  = 1'b1;

  logic [0:0]         r_state;
  logic [c_PTR_W-1:0] r_last;
  logic [c_PTR_W-1:0] r_owner;
  logic [NUM_REQ-1:0] r_grant;
  logic [7:0]         r_x;
  logic [6:0]         r_y;
  logic [2:0]         r_colour;
  logic               r_plot;

  logic               w_found;
  logic [c_PTR_W-1:0] w_pick;
  int                 w_best;
  int                 w_dist;
  logic               w_req_o;
  logic               w_valid_o;
  logic               w_last_o;
  logic [7:0]         w_x_o;
  logic [6:0]         w_y_o;
  logic [2:0]         w_colour_o;
  logic               w_accept;
  logic               w_end;
  logic               w_expire;

  // Round-robin pick: smallest distance after r_last among active requests
  always_comb begin
    w_best = NUM_REQ;
    w_dist = 0;
    w_pick = r_last;
    for (int j = 0; j < NUM_REQ; j++) begin
      w_dist = (j + NUM_REQ - 1 - int'(r_last)) % NUM_REQ;
      if (bus.iReq[j] && (w_dist < w_best)) begin
        w_best = w_dist;
        w_pick = c_PTR_W'(j);
      end
    end
    w_found = (w_best < NUM_REQ);
  end

  // Select the current owner's request/pixel slice; non-owners are ignored
  always_comb begin
    w_req_o    = 1'b0;
    w_valid_o  = 1'b0;
    w_last_o   = 1'b0;
    w_x_o      = '0;
    w_y_o      = '0;
    w_colour_o = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (r_owner == c_PTR_W'(j)) begin
        w_req_o    = bus.iReq[j];
        w_valid_o  = bus.iValid[j];
        w_last_o   = bus.iLast[j];
        w_x_o      = bus.iX[8*j +: 8];
        w_y_o      = bus.iY[7*j +: 7];
        w_colour_o = bus.iColour[3*j +: 3];
      end
    end
  end

  // A dropped request still lets that cycle's valid pixel through
  assign w_accept = (r_state == c_ST_OWN) && w_valid_o;
  assign w_end    = (r_state == c_ST_OWN) && ((w_accept && w_last_o) || !w_req_o);

`ifdef ARB_WATCHDOG_EN
  localparam int c_CNT_W = $clog2(MAX_BURST + 1);

  logic [c_CNT_W-1:0] r_cnt;
  logic               r_timeout;

  // A normal burst end in the same cycle wins over the watchdog
  assign w_expire = (r_state == c_ST_OWN) && !w_end &&
                    (r_cnt == c_CNT_W'(MAX_BURST - 1));

  // Count OWN cycles; held at zero in IDLE so each burst starts from zero
  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= w_expire;
      if (r_state == c_ST_IDLE) r_cnt <= '0;
      else                      r_cnt <= r_cnt + c_CNT_W'(1);
    end
  end

  assign bus.oTimeout = r_timeout;
`else
  assign w_expire     = 1'b0;
  assign bus.oTimeout = 1'b0;
`endif

  // Arbitration FSM: IDLE decides, OWN holds the grant until the burst ends
  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      r_state <= c_ST_IDLE;
      r_last  <= c_PTR_W'(NUM_REQ - 1);
      r_owner <= '0;
      r_grant <= '0;
    end else begin
      case (r_state)
        c_ST_IDLE: begin
          if (w_found) begin
            r_state <= c_ST_OWN;
            r_owner <= w_pick;
            r_grant <= {{(NUM_REQ-1){1'b0}}, 1'b1} << w_pick;
          end
        end
        c_ST_OWN: begin
          if (w_end || w_expire) begin
            r_state <= c_ST_IDLE;
            r_last  <= r_owner;
            r_grant <= '0;
          end
        end
        default: begin
          r_state <= c_ST_IDLE;
          r_grant <= '0;
        end
      endcase
    end
  end

  // Output pixel register: loads on acceptance, plot strobe follows acceptance
  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      r_x      <= '0;
      r_y      <= '0;
      r_colour <= '0;
      r_plot   <= 1'b0;
    end else begin
      r_plot <= w_accept;
      if (w_accept) begin
        r_x      <= w_x_o;
        r_y      <= w_y_o;
        r_colour <= w_colour_o;
      end
    end
  end

  assign bus.oGrant  = r_grant;
  assign bus.oBusy   = |r_grant;
  assign bus.oX      = r_x;
  assign bus.oY      = r_y;
  assign bus.oColour = r_colour;
  assign bus.oPlot   = r_plot;

endmodule
`default_nettype wire

// File: tb/tb_pixel_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pixel_port_arbiter
//  Purpose  : Self-checking bench for pixel_port_arbiter with a behavioural
//             ownership model (owner index or -1, round-robin by arithmetic).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pixel_port_arbiter;
  localparam int NR = 2;
`ifdef ARB_WATCHDOG_EN
  localparam int MB = 8;
`else
  localparam int MB = 19200;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  pixel_port_arbiter_if #(.NUM_REQ(NR)) bus ();

  pixel_port_arbiter #(.NUM_REQ(NR), .MAX_BURST(MB)) dut (
    .iClock (clk),
    .iReset (rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  int         m_owner;
  int         m_last;
  int         m_cycles;
  logic [7:0] m_x;
  logic [6:0] m_y;
  logic [2:0] m_c;
  logic       m_plot;
  logic       m_to;

  task automatic model_reset();
    m_owner = -1; m_last = NR - 1; m_cycles = 0;
    m_x = '0; m_y = '0; m_c = '0; m_plot = 1'b0; m_to = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [NR-1:0] g;
    g = '0;
    if (m_owner >= 0) g[m_owner] = 1'b1;
    chk("grant",   32'(bus.oGrant),  32'(g));
    chk("busy",    32'(bus.oBusy),   32'(m_owner >= 0));
    chk("plot",    32'(bus.oPlot),   32'(m_plot));
    chk("x",       32'(bus.oX),      32'(m_x));
    chk("y",       32'(bus.oY),      32'(m_y));
    chk("colour",  32'(bus.oColour), 32'(m_c));
    chk("timeout", 32'(bus.oTimeout), 32'(m_to));
  endtask

  task automatic drv(input logic [NR-1:0] rq, input logic [NR-1:0] vl, input logic [NR-1:0] ls,
                     input logic [8*NR-1:0] xs, input logic [7*NR-1:0] ys, input logic [3*NR-1:0] cs);
    bus.iReq = rq; bus.iValid = vl; bus.iLast = ls;
    bus.iX = xs; bus.iY = ys; bus.iColour = cs;
  endtask

  // One clock: predict from current inputs, advance, then compare
  task automatic step();
    int nxt, nlast, ncyc, idx, o;
    logic [7:0] nx; logic [6:0] ny; logic [2:0] nc;
    logic np, nt;
    bit acc, endb;
    nxt = m_owner; nlast = m_last; ncyc = m_cycles;
    nx = m_x; ny = m_y; nc = m_c; np = 1'b0; nt = 1'b0;
    if (m_owner < 0) begin
      for (int k = 1; k <= NR; k++) begin
        idx = (m_last + k) % NR;
        if (nxt < 0 && bus.iReq[idx]) nxt = idx;
      end
      ncyc = 0;
    end else begin
      o    = m_owner;
      acc  = bus.iValid[o];
      np   = acc;
      if (acc) begin
        nx = bus.iX[8*o +: 8]; ny = bus.iY[7*o +: 7]; nc = bus.iColour[3*o +: 3];
      end
      endb = (acc && bus.iLast[o]) || !bus.iReq[o];
`ifdef ARB_WATCHDOG_EN
      nt = !endb && (m_cycles + 1 == MB);
`endif
      if (endb || nt) begin
        nxt = -1; nlast = o;
      end
      ncyc = m_cycles + 1;
    end
    @(posedge clk); #1;
    if (rst) model_reset();
    else begin
      m_owner = nxt; m_last = nlast; m_cycles = ncyc;
      m_x = nx; m_y = ny; m_c = nc; m_plot = np; m_to = nt;
    end
    check_all();
  endtask

  int cnt [NR];
  int own_before;
  int plots;
  logic [NR-1:0] ls;

  initial begin
    model_reset();
    drv('0, '0, '0, '0, '0, '0);

    // Reset state
    step(); step();
    rst = 1'b0;
    step();

    // Single requester, four-pixel burst x=10..13, y=5, colour=1
    drv(2'b01, 2'b00, 2'b00, '0, '0, '0);
    step();
    plots = 0;
    for (int i = 0; i < 4; i++) begin
      drv(2'b01, 2'b01, (i == 3) ? 2'b01 : 2'b00, 16'(10 + i), 14'd5, 6'd1);
      step();
      if (bus.oPlot) plots++;
    end
    chk("burst_plots", 32'(plots), 32'd4);
    drv('0, '0, '0, '0, '0, '0);
    step(); step();

    // Both requesting, two-pixel bursts; requester 1 always shows x=99
    cnt[0] = 0; cnt[1] = 0;
    for (int i = 0; i < 14; i++) begin
      for (int k = 0; k < NR; k++) ls[k] = cnt[k][0];
      drv(2'b11, 2'b11, ls, {8'd99, 8'(20 + cnt[0])}, {7'd3, 7'd4}, {3'd6, 3'd2});
      own_before = m_owner;
      step();
      if (own_before >= 0) cnt[own_before]++;
    end
    chk("rr_share", 32'(cnt[0] > 0 && cnt[1] > 0), 32'd1);
    drv('0, '0, '0, '0, '0, '0);
    step(); step();

    // Reset mid-burst after two pixels, outputs clear without a clock edge
    drv(2'b01, 2'b00, 2'b00, '0, '0, '0);
    step();
    for (int i = 0; i < 2; i++) begin
      drv(2'b01, 2'b01, 2'b00, 16'(40 + i), 14'd7, 6'd5);
      step();
    end
    rst = 1'b1;
    #1;
    chk("async_grant", 32'(bus.oGrant), 32'd0);
    chk("async_plot",  32'(bus.oPlot),  32'd0);
    chk("async_x",     32'(bus.oX),     32'd0);
    chk("async_busy",  32'(bus.oBusy),  32'd0);
    model_reset();
    drv(2'b10, 2'b00, 2'b00, '0, '0, '0);
    step();
    rst = 1'b0;
    step();

    // Owner drops request without last: that cycle's pixel still emitted
    drv(2'b10, 2'b10, 2'b00, {8'd50, 8'd0}, {7'd9, 7'd0}, {3'd4, 3'd0});
    step();
    drv(2'b00, 2'b10, 2'b00, {8'd77, 8'd0}, {7'd11, 7'd0}, {3'd7, 3'd0});
    step();
    drv('0, '0, '0, '0, '0, '0);
    step();

    // Long burst without last (revoked by the watchdog when enabled)
    for (int i = 0; i < 14; i++) begin
      drv(2'b11, 2'b11, 2'b00, {8'd200, 8'(100 + i)}, {7'd1, 7'd2}, {3'd3, 3'd5});
      step();
    end
    drv('0, '0, '0, '0, '0, '0);
    step(); step();

    // Randomised traffic
    for (int i = 0; i < 300; i++) begin
      logic [NR-1:0] rq, vl, lt;
      for (int k = 0; k < NR; k++) begin
        rq[k] = ($urandom_range(0, 7) != 0);
        vl[k] = $urandom_range(0, 1) == 1;
        lt[k] = ($urandom_range(0, 3) == 0);
      end
      drv(rq, vl, lt, 16'($urandom), 14'($urandom), 6'($urandom));
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire
